ks_add_scheduler: RTL and testbench
===================================

KS_ADD_SCHEDULER -- requirements
Module: ks_add_scheduler

Interface
REQ-001 SHALL have parameter NBITS, default 16: width of the shared kogge_stone adder slice.
REQ-002 SHALL have parameter NWORDS, default 4: slices per operation, so operand width W = NBITS*NWORDS (64).
REQ-003 SHALL use one clock with synchronous, active-high reset, ports named as follows.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 2: per-requester request valid.
REQ-007 SHALL have port req_ready, output, 2: per-requester accept; at most one bit high.
REQ-008 SHALL have port req_a, input, 2*W: operand A, requester n at bits [n*W +: W].
REQ-009 SHALL have port req_b, input, 2*W: operand B, same packing.
REQ-010 SHALL have port req_sub, input, 2: 1 = A-B, 0 = A+B.
REQ-011 SHALL have port rsp_valid, output, 1: result valid.
REQ-012 SHALL have port rsp_ready, input, 1: result consumer ready.
REQ-013 SHALL have port rsp_id, output, 1: requester index of the result.
REQ-014 SHALL have port rsp_sum, output, W: result.
REQ-015 SHALL have port rsp_cout, output, 1: final carry out (for subtract, 1 = no borrow).
REQ-016 SHALL have port rsp_ovf, output, 1: two's-complement signed overflow.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE: IDLE->RUN on handshake; RUN->DONE after beat NWORDS-1; DONE->IDLE on rsp_valid&&rsp_ready.
REQ-018 SHALL drive req_ready combinationally, only in IDLE and not in rst, to the single granted requester among those with req_valid high.
REQ-019 SHALL arbitrate round-robin: when both request, the priority pointer wins; after each grant the pointer moves to the other requester; reset pointer = 0.
REQ-020 SHALL capture A, B^{W{sub}}, sub and id only on the handshake edge; later operand changes SHALL be ignored.
REQ-021 SHALL accept requester valid deasserting without handshake, with no state change.
REQ-022 SHALL in RUN beat k (0..NWORDS-1) feed slice k of A and B' to the adder, with carry_in = sub for k=0, otherwise the registered carry_out of beat k-1.
REQ-023 SHALL register each beat's sum_out into rsp_sum slice k and carry_out into the carry register on the beat's ending edge.
REQ-024 SHALL compute rsp_ovf = (A[W-1]==B'[W-1]) && (rsp_sum[W-1]!=A[W-1]); rsp_cout = carry after beat NWORDS-1.
REQ-025 SHALL raise rsp_valid on the NWORDS-th edge after the accepting edge (latency NWORDS cycles) and hold rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf stable until rsp_ready.
REQ-026 SHALL never accept a request in RUN or DONE; minimum issue interval NWORDS+2 cycles.
REQ-027 SHALL deassert rsp_valid on the edge where rsp_valid&&rsp_ready; data outputs may hold their last value.

Reset
REQ-028 SHALL on rst enter IDLE, set pointer=0, beat counter=0, carry=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0.
REQ-029 SHALL abandon any operation in RUN or DONE on rst with no response produced; req_ready=0 while rst high.

Structure
REQ-030 SHALL place NBITS, NWORDS, W and the state typedef {IDLE,RUN,DONE} in shared package ks_sched_pkg.
REQ-031 SHALL instantiate the existing kogge_stone adder exactly once as its only sub-module; beat counter width $clog2(NWORDS).

Verification
REQ-032 SHALL check: req0 A=0x0000_0000_0000_FFFF, B=1, add -> sum 0x0000_0000_0001_0000, cout 0, ovf 0, id 0, rsp_valid 4 cycles after accept.
REQ-033 SHALL check: A=0xFFFF_FFFF_FFFF_FFFF, B=1, add -> sum 0, cout 1, ovf 0 (carry across all 4 beats).
REQ-034 SHALL check: req1 A=5, B=7, sub -> sum 0xFFFF_FFFF_FFFF_FFFE, cout 0, ovf 0, id 1.
REQ-035 SHALL check: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> sum 0x8000_0000_0000_0000, ovf 1, cout 0.
REQ-036 SHALL check: both req_valid held high from reset -> grants 0,1,0,1; rsp_ready low 3 cycles in DONE -> outputs stable, no req_ready.
REQ-037 SHALL check: rst pulsed during RUN beat 2 -> next cycle rsp_valid 0, all outputs 0, first grant afterwards to req0 when both request.

Source files
------------

// File: rtl/ks_sched_pkg.sv
// Shared sizing and state encoding for the multi-beat add/sub scheduler.
package ks_sched_pkg;

    localparam int unsigned NBITS  = 16;
    localparam int unsigned NWORDS = 4;
    localparam int unsigned W      = NBITS * NWORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/kogge_stone.sv
// NBITS-wide parallel-prefix (Kogge-Stone) adder with carry in/out.
module kogge_stone #(
    parameter int unsigned NBITS = 16
) (
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic             carry_in,
    output logic [NBITS-1:0] sum_out,
    output logic             carry_out
);

    localparam int NB  = int'(NBITS);
    localparam int LVL = $clog2(NBITS);

    logic [NBITS-1:0] prop;
    logic [NBITS-1:0] gen;
    logic [NBITS-1:0] grp_p;
    logic [NBITS-1:0] gen_n;
    logic [NBITS-1:0] grp_p_n;
    logic [NBITS-1:0] carries;

    // Prefix tree; carry_in is folded into bit 0's generate so G[i] is the carry into bit i+1.
    always_comb begin
        prop    = a ^ b;
        gen     = a & b;
        gen[0]  = gen[0] | (prop[0] & carry_in);
        grp_p   = prop;
        gen_n   = '0;
        grp_p_n = '0;
        for (int l = 0; l < LVL; l++) begin
            gen_n   = gen;
            grp_p_n = grp_p;
            for (int i = (1 << l); i < NB; i++) begin
                gen_n[i]   = gen[i] | (grp_p[i] & gen[i - (1 << l)]);
                grp_p_n[i] = grp_p[i] & grp_p[i - (1 << l)];
            end
            gen   = gen_n;
            grp_p = grp_p_n;
        end
        carries   = {gen[NBITS-2:0], carry_in};
        sum_out   = prop ^ carries;
        carry_out = gen[NBITS-1];
    end

endmodule

// File: rtl/ks_add_scheduler.sv
// Two-requester round-robin add/sub engine reusing one NBITS adder slice over NWORDS beats.
module ks_add_scheduler
    import ks_sched_pkg::*;
#(
    parameter int unsigned NBITS  = ks_sched_pkg::NBITS,
    parameter int unsigned NWORDS = ks_sched_pkg::NWORDS,
    localparam int unsigned OPW   = NBITS * NWORDS,
    localparam int unsigned CW    = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*OPW-1:0] req_a,
    input  logic [2*OPW-1:0] req_b,
    input  logic [1:0]       req_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [OPW-1:0]   rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf
);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [CW-1:0]    beat_q, beat_d;
    logic             carry_q, carry_d;
    logic [OPW-1:0]   a_q, a_d;
    logic [OPW-1:0]   b_q, b_d;
    logic             sub_q, sub_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [OPW-1:0]   rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_ovf_q, rsp_ovf_d;

    logic             gnt_vld;
    logic             gnt_id;
    logic [NBITS-1:0] add_a;
    logic [NBITS-1:0] add_b;
    logic             add_cin;
    logic [NBITS-1:0] add_sum;
    logic             add_cout;
    logic             last_beat;

    // Round-robin grant: pointer requester first, other one otherwise; only while idle.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_id    = 1'b0;
        req_ready = 2'b00;
        if (state_q == IDLE && !rst) begin
            if (req_valid[ptr_q]) begin
                gnt_vld = 1'b1;
                gnt_id  = ptr_q;
            end else if (req_valid[~ptr_q]) begin
                gnt_vld = 1'b1;
                gnt_id  = ~ptr_q;
            end
        end
        if (gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // Current beat's operand slices; beat 0 takes sub as carry-in to complete two's complement.
    always_comb begin
        add_a     = a_q[beat_q*NBITS +: NBITS];
        add_b     = b_q[beat_q*NBITS +: NBITS];
        add_cin   = (beat_q == '0) ? sub_q : carry_q;
        last_beat = (beat_q == CW'(NWORDS - 1));
    end

    kogge_stone #(
        .NBITS(NBITS)
    ) u_adder (
        .a        (add_a),
        .b        (add_b),
        .carry_in (add_cin),
        .sum_out  (add_sum),
        .carry_out(add_cout)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        beat_d      = beat_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_ovf_d   = rsp_ovf_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    state_d  = RUN;
                    ptr_d    = ~gnt_id;
                    beat_d   = '0;
                    a_d      = req_a[gnt_id*OPW +: OPW];
                    b_d      = req_b[gnt_id*OPW +: OPW] ^ {OPW{req_sub[gnt_id]}};
                    sub_d    = req_sub[gnt_id];
                    rsp_id_d = gnt_id;
                end
            end
            RUN: begin
                rsp_sum_d[beat_q*NBITS +: NBITS] = add_sum;
                carry_d = add_cout;
                if (last_beat) begin
                    state_d     = DONE;
                    beat_d      = '0;
                    rsp_valid_d = 1'b1;
                    rsp_cout_d  = add_cout;
                    rsp_ovf_d   = (a_q[OPW-1] == b_q[OPW-1]) && (add_sum[NBITS-1] != a_q[OPW-1]);
                end else begin
                    beat_d = beat_q + CW'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            beat_q      <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            beat_q      <= beat_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_ks_add_scheduler.sv
// Scoreboard bench for ks_add_scheduler: reference model is full-width W+1 arithmetic.
module tb_ks_add_scheduler;

    localparam int NB = 16;
    localparam int NW = 4;
    localparam int W  = NB * NW;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]     req_sub;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           rsp_ovf;

    typedef struct {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   grants[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic vld_prev = 1'b0;

    ks_add_scheduler #(.NBITS(NB), .NWORDS(NW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_sub  (req_sub),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
        .rsp_cout (rsp_cout),
        .rsp_ovf  (rsp_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input int acc);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] bp;
        bp     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bp} + (W+1)'(s);
        e.id   = id;
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bp[W-1]) && (e.sum[W-1] != a[W-1]);
        e.acc  = acc;
        return e;
    endfunction

    // Response checker and accept recorder, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rsp_valid) chk("busy_no_rdy", 128'(req_ready), 128'(0));
            if (rsp_valid && !vld_prev) begin
                if (sb.size() > 0) chk("latency", 128'(cyc - sb[0].acc), 128'(NW + 1));
                else chk("spurious_rsp", 128'(1), 128'(0));
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_id", 128'(rsp_id), 128'(e.id));
                chk("rsp_sum", 128'(rsp_sum), 128'(e.sum));
                chk("rsp_cout", 128'(rsp_cout), 128'(e.cout));
                chk("rsp_ovf", 128'(rsp_ovf), 128'(e.ovf));
            end
            for (int n = 0; n < 2; n++) begin
                if (req_valid[n] && req_ready[n]) begin
                    sb.push_back(model(1'(n), req_a[n*W +: W], req_b[n*W +: W], req_sub[n], cyc));
                    grants.push_back(n);
                end
            end
        end
        vld_prev <= rsp_valid;
    end

    task automatic issue(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic got;
        @(posedge clk); #1;
        req_valid[n]       = 1'b1;
        req_a[n*W +: W]    = a;
        req_b[n*W +: W]    = b;
        req_sub[n]         = s;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready[n]) got = 1'b1;
        end
        if (!got) chk("issue_timeout", 128'(0), 128'(1));
        @(posedge clk); #1;
        req_valid[n]    = 1'b0;
        req_a[n*W +: W] = {$urandom, $urandom};
        req_b[n*W +: W] = {$urandom, $urandom};
        req_sub[n]      = ~s;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        req_valid = 2'b11;
        req_a     = {64'd10, 64'd1};
        req_b     = {64'd3, 64'd2};
        req_sub   = 2'b10;
        rsp_ready = 1'b0;

        // Reset state with both requesters already pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_sum", 128'(rsp_sum), 128'(0));
        chk("rst_rsp_id", 128'(rsp_id), 128'(0));
        chk("rst_cout_ovf", 128'({rsp_cout, rsp_ovf}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Response held while consumer stalls in DONE.
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        if (!seen) chk("stall_timeout", 128'(0), 128'(1));
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_valid", 128'(rsp_valid), 128'(1));
            chk("stall_sum", 128'(rsp_sum), 128'(64'd3));
            chk("stall_id", 128'(rsp_id), 128'(0));
            chk("stall_no_rdy", 128'(req_ready), 128'(0));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;

        // Continue with both requesting until four grants are observed.
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (grants.size() >= 4) seen = 1'b1;
        end
        if (!seen) chk("grant_timeout", 128'(0), 128'(1));
        @(posedge clk); #1;
        req_valid = 2'b00;
        drain();
        for (int g = 0; g < 4; g++) begin
            chk("rr_grant", 128'(grants.size() > g ? grants[g] : 9), 128'(g % 2));
        end

        // Directed arithmetic cases.
        issue(0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
        issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        issue(1, 64'd5, 64'd7, 1'b1);
        issue(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        issue(1, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        issue(1, 64'd0, 64'd0, 1'b1);
        drain();

        // Valid pulse from the idle requester while busy: no accept, no extra response.
        issue(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk("run_no_rdy", 128'(req_ready), 128'(0));
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drain();

        // Random operations.
        for (int r = 0; r < 8; r++) begin
            issue(int'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)));
        end
        drain();

        // Reset during beat 2 abandons the operation and restores pointer 0.
        issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("rst_hi_no_rdy", 128'(req_ready), 128'(0));
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        chk("midrst_valid", 128'(rsp_valid), 128'(0));
        chk("midrst_sum", 128'(rsp_sum), 128'(0));
        chk("midrst_misc", 128'({rsp_id, rsp_cout, rsp_ovf}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 128'(req_ready), 128'(2'b01));
        @(posedge clk); #1;
        req_valid = 2'b00;
        drain();

        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
